instruction_fetch_unit: RTL and testbench

Fetches one 16-bit instruction from byte-wide memory into an instruction register. Uses the program counter held in AddressRegisterFile: drives the memory address from ARF OutD, reads low byte then high byte, and commands ARF to increment PC after each accepted byte. Sits between AddressRegisterFile (address source) and the instruction decoder (consumer of IR).

---
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetches one 16-bit instruction (low byte, then high byte) from byte-wide memory into IR, addressed by the ARF program counter.
// Latency: 3 cycles from an accepted Start to the Valid pulse when MemReady stays high; each MemReady-low cycle in LOW/HIGH adds one.
// Backpressure: MemReady low stalls in LOW/HIGH with no PC increment; Start is ignored while Busy and is never queued.
module instruction_fetch_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] PCIn,
  input  logic [7:0]  MemData,
  input  logic        MemReady,
  output logic        MemRead,
  output logic [15:0] MemAddr,
  output logic [1:0]  ARFOutDSel,
  output logic [2:0]  ARFRegSel,
  output logic [1:0]  ARFFunSel,
  output logic [15:0] IR,
  output logic        Busy,
  output logic        Valid
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10,
    DONE = 2'b11
  } fetchState_t;

  localparam logic [2:0] REG_SEL_PC   = 3'b100;
  localparam logic [2:0] REG_SEL_NONE = 3'b000;
  localparam logic [1:0] FUN_INC      = 2'b01;
  localparam logic [1:0] FUN_NONE     = 2'b00;
  localparam logic [1:0] OUTD_PC      = 2'b00;

  fetchState_t state;
  fetchState_t nextState;
  logic        loadLow;
  logic        loadHigh;
  logic        byteAccept;

  // The PC always sits on ARF OutD, so the memory address is a straight pass-through.
  assign MemAddr    = PCIn;
  assign ARFOutDSel = OUTD_PC;

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic plus the state-decoded status outputs and byte-capture strobes.
  always_comb begin
    nextState = state;
    MemRead   = 1'b0;
    Busy      = 1'b0;
    Valid     = 1'b0;
    loadLow   = 1'b0;
    loadHigh  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nextState = LOW;
        end
      end
      LOW: begin
        MemRead = 1'b1;
        Busy    = 1'b1;
        if (MemReady) begin
          loadLow   = 1'b1;
          nextState = HIGH;
        end
      end
      HIGH: begin
        MemRead = 1'b1;
        Busy    = 1'b1;
        if (MemReady) begin
          loadHigh  = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        Valid     = 1'b1;
        nextState = Start ? LOW : IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // A PC increment is issued only in the same cycle a byte is accepted, so the address steps with the data.
  always_comb begin
    byteAccept = loadLow | loadHigh;
    ARFRegSel  = byteAccept ? REG_SEL_PC : REG_SEL_NONE;
    ARFFunSel  = (ARFRegSel != REG_SEL_NONE) ? FUN_INC : FUN_NONE;
  end

  // Instruction register: each half changes only on its own capture edge; reset discards any partial fetch.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      IR <= 16'h0000;
    end else begin
      if (loadLow) begin
        IR[7:0] <= MemData;
      end
      if (loadHigh) begin
        IR[15:8] <= MemData;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] PCIn;
  logic [7:0]  MemData;
  logic        MemReady;
  logic        MemRead;
  logic [15:0] MemAddr;
  logic [1:0]  ARFOutDSel;
  logic [2:0]  ARFRegSel;
  logic [1:0]  ARFFunSel;
  logic [15:0] IR;
  logic        Busy;
  logic        Valid;

  instruction_fetch_unit dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .PCIn      (PCIn),
    .MemData   (MemData),
    .MemReady  (MemReady),
    .MemRead   (MemRead),
    .MemAddr   (MemAddr),
    .ARFOutDSel(ARFOutDSel),
    .ARFRegSel (ARFRegSel),
    .ARFFunSel (ARFFunSel),
    .IR        (IR),
    .Busy      (Busy),
    .Valid     (Valid)
  );

  // Environment: byte memory and the ARF program counter.
  logic [7:0]  mem [0:65535];
  logic [15:0] pc;
  logic        pcSet;
  logic [15:0] pcSetVal;

  assign PCIn    = pc;
  assign MemData = mem[MemAddr];

  always @(posedge Clock) begin
    if (pcSet) pc <= pcSetVal;
    else if (ARFRegSel == 3'b100 && ARFFunSel == 2'b01) pc <= pc + 16'd1;
  end

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Scoreboard
  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;
  exp_t expQ[$];

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] pcModel;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic setPc(input logic [15:0] v);
    pcSetVal = v;
    pcSet    = 1'b1;
    tick();
    pcSet    = 1'b0;
    pcModel  = v;
  endtask

  // Reference: a fetch returns {mem[pc+1], mem[pc]} and leaves the PC two higher (16-bit wrap).
  task automatic pushExp();
    exp_t e;
    e.ir    = {mem[pcModel + 16'd1], mem[pcModel]};
    pcModel = pcModel + 16'd2;
    e.pc    = pcModel;
    expQ.push_back(e);
  endtask

  // Monitor: protocol invariants every cycle, IR/PC comparison whenever Valid is presented.
  always @(negedge Clock) begin
    if (Reset) begin
      exp_t e;
      check("memaddr_eq_pc", 32'(MemAddr), 32'(pc));
      check("outdsel", 32'(ARFOutDSel), 32'h0);
      if (ARFRegSel != 3'b000) begin
        check("inc_regsel", 32'(ARFRegSel), 32'h4);
        check("inc_funsel", 32'(ARFFunSel), 32'h1);
        check("inc_with_accept", 32'({MemRead, MemReady}), 32'h3);
      end else begin
        check("noinc_funsel", 32'(ARFFunSel), 32'h0);
      end
      if (Valid) begin
        if (expQ.size() == 0) begin
          check("unexpected_valid", 32'(Valid), 32'h0);
        end else begin
          e = expQ.pop_front();
          check("ir", 32'(IR), 32'(e.ir));
          check("pc_after_fetch", 32'(pc), 32'(e.pc));
        end
      end
    end
  end

  task automatic directedFetch(input logic [15:0] readyPat, input logic [15:0] startPat, input int expLat);
    int cyc;
    cyc      = 0;
    Start    = 1'b1;
    MemReady = 1'b1;
    pushExp();
    while (cyc < 40) begin
      tick();
      cyc++;
      if (Valid) break;
      Start    = startPat[cyc-1];
      MemReady = readyPat[cyc-1];
    end
    Start = 1'b0;
    check("latency", 32'(cyc), 32'(expLat));
    tick();
  endtask

  initial begin
    int cyc;
    int nv;
    int v1;
    int v2;
    bit got;

    Reset    = 1'b0;
    Start    = 1'b0;
    MemReady = 1'b0;
    pcSet    = 1'b0;
    pcSetVal = 16'h0000;
    pcModel  = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset state
    #3;
    check("rst_ir", 32'(IR), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_valid", 32'(Valid), 32'h0);
    check("rst_memread", 32'(MemRead), 32'h0);
    check("rst_regsel", 32'(ARFRegSel), 32'h0);
    check("rst_funsel", 32'(ARFFunSel), 32'h0);
    setPc(16'h0020);
    tick();
    Reset = 1'b1;
    tick();

    // Single fetch
    mem[16'h0020] = 8'h34;
    mem[16'h0021] = 8'h12;
    mem[16'h0022] = 8'hCD;
    mem[16'h0023] = 8'hAB;
    directedFetch(16'hFFFF, 16'h0000, 3);

    // Wait states: two in LOW, one in HIGH
    setPc(16'h0020);
    directedFetch(16'h0014, 16'h0000, 6);

    // Back-to-back with Start held
    setPc(16'h0020);
    Start    = 1'b1;
    MemReady = 1'b1;
    pushExp();
    pushExp();
    nv = 0; v1 = 0; v2 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (Valid) begin
        if (nv == 0) v1 = c;
        else if (nv == 1) v2 = c;
        nv++;
      end else if (nv >= 1) begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check("b2b_first_valid", 32'(v1), 32'd3);
    check("b2b_second_valid", 32'(v2), 32'd6);
    check("b2b_valid_count", 32'(nv), 32'd2);

    // PC wrap
    mem[16'hFFFF] = 8'h78;
    mem[16'h0000] = 8'h56;
    setPc(16'hFFFF);
    directedFetch(16'hFFFF, 16'h0000, 3);

    // Start during Busy is ignored
    setPc(16'h0020);
    directedFetch(16'hFFFF, 16'h0002, 3);
    repeat (4) tick();

    // Reset mid-HIGH with the low byte already captured
    mem[16'h0040] = 8'hA5;
    mem[16'h0041] = 8'h5A;
    setPc(16'h0040);
    Start    = 1'b1;
    MemReady = 1'b1;
    pushExp();
    tick();
    Start = 1'b0;
    tick();
    MemReady = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check("midrst_ir", 32'(IR), 32'h0);
    check("midrst_busy", 32'(Busy), 32'h0);
    check("midrst_valid", 32'(Valid), 32'h0);
    check("midrst_memread", 32'(MemRead), 32'h0);
    check("midrst_regsel", 32'(ARFRegSel), 32'h0);
    check("midrst_pc_kept", 32'(pc), 32'h41);
    expQ.delete();
    pcModel = 16'h0041;
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    check("postrst_busy", 32'(Busy), 32'h0);
    check("postrst_ir", 32'(IR), 32'h0);

    // Randomized fetches across a wrap, random wait states, spurious Starts and idle gaps
    setPc(16'hFF80);
    for (int n = 0; n < 200; n++) begin
      Start    = 1'b1;
      MemReady = ($urandom_range(0, 3) != 0);
      pushExp();
      cyc = 0;
      got = 1'b0;
      while (cyc < 40) begin
        tick();
        cyc++;
        if (Valid) begin
          got = 1'b1;
          break;
        end
        Start    = ($urandom_range(0, 3) == 0);
        MemReady = ($urandom_range(0, 3) != 0);
      end
      Start = 1'b0;
      check("valid_within_budget", 32'(got), 32'h1);
      if (!got) begin
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        expQ.delete();
        pcModel = pc;
        tick();
      end else if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end

    repeat (5) tick();
    check("queue_drained", 32'(expQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
